db_fsm_n: RTL and testbench



---
 rtl/db_fsm_n.sv | 137 +++++++++++++
 tb/tb_db_fsm_n.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/db_fsm_n.sv
`default_nettype none
// ============================================================================
// Module      : db_fsm_n
// Description : N-channel switch debouncer. Each channel has a four-state FSM
//               (ZERO / WAIT1 / ONE / WAIT0) and a stability counter. It drives
//               a registered debounced level and one-cycle rise/fall ticks.
//               Optional macro DB_FSM_N_SYNC_EN adds a 2-flop input
//               synchronizer per channel, which adds two cycles of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module db_fsm_n #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw,
    output logic [N-1:0] db,
    output logic [N-1:0] db_rise,
    output logic [N-1:0] db_fall
);

    localparam int               CNT_W     = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [1:0] c_ZERO  = 2'd0;
    localparam logic [1:0] c_WAIT1 = 2'd1;
    localparam logic [1:0] c_ONE   = 2'd2;
    localparam logic [1:0] c_WAIT0 = 2'd3;

    // Input level seen by the channel FSMs
    logic [N-1:0] w_sw_s;

`ifdef DB_FSM_N_SYNC_EN
    logic [N-1:0] r_sync_meta;
    logic [N-1:0] r_sync_out;

    // Two-flop synchronizer for pins that are asynchronous to clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_meta <= '0;
            r_sync_out  <= '0;
        end else begin
            r_sync_meta <= sw;
            r_sync_out  <= r_sync_meta;
        end
    end

    assign w_sw_s = r_sync_out;
`else
    assign w_sw_s = sw;
`endif

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            logic [1:0]       r_state;
            logic [1:0]       w_state_next;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_next;
            logic             w_db_d;
            logic             w_rise_d;
            logic             w_fall_d;
            logic             r_db;
            logic             r_rise;
            logic             r_fall;

            // State, counter and registered outputs; reset aborts any pending qualification
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= c_ZERO;
                    r_cnt   <= '0;
                    r_db    <= 1'b0;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                    r_db    <= w_db_d;
                    r_rise  <= w_rise_d;
                    r_fall  <= w_fall_d;
                end
            end

            // Next state and counter: any bounce during WAIT restarts from zero
            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = '0;
                case (r_state)
                    c_ZERO: begin
                        if (w_sw_s[gi]) begin
                            w_state_next = c_WAIT1;
                        end
                    end
                    c_WAIT1: begin
                        if (!w_sw_s[gi]) begin
                            w_state_next = c_ZERO;
                        end else if (r_cnt == c_CNT_MAX) begin
                            w_state_next = c_ONE;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                    c_ONE: begin
                        if (!w_sw_s[gi]) begin
                            w_state_next = c_WAIT0;
                        end
                    end
                    c_WAIT0: begin
                        if (w_sw_s[gi]) begin
                            w_state_next = c_ONE;
                        end else if (r_cnt == c_CNT_MAX) begin
                            w_state_next = c_ZERO;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_next = c_ZERO;
                    end
                endcase
            end

            // Output decode from the next state so that db and the ticks line up with the state change
            always_comb begin
                w_db_d   = (w_state_next == c_ONE) || (w_state_next == c_WAIT0);
                w_rise_d = (r_state == c_WAIT1) && (w_state_next == c_ONE);
                w_fall_d = (r_state == c_WAIT0) && (w_state_next == c_ZERO);
            end

            assign db[gi]      = r_db;
            assign db_rise[gi] = r_rise;
            assign db_fall[gi] = r_fall;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_db_fsm_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_db_fsm_n
// Description : Self-checking bench for db_fsm_n (N=2, STABLE_CYCLES=8).
//               Uses a run-length model: db flips after the sampled input has
//               differed from db for STABLE_CYCLES+1 consecutive edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_db_fsm_n;

    localparam int N = 2;
    localparam int S = 8;
`ifdef DB_FSM_N_SYNC_EN
    localparam int LAT = S + 3;
`else
    localparam int LAT = S + 1;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] sw    = 2'b11;
    logic [N-1:0] db;
    logic [N-1:0] db_rise;
    logic [N-1:0] db_fall;

    int n_err    = 0;
    int n_checks = 0;
    int rise_cnt [N];
    int fall_cnt [N];

    // model state
    logic [N-1:0] m_db   = '0;
    logic [N-1:0] m_rise = '0;
    logic [N-1:0] m_fall = '0;
    int           m_run [N];
`ifdef DB_FSM_N_SYNC_EN
    logic [N-1:0] m_q1 = '0;
    logic [N-1:0] m_q2 = '0;
`endif

    db_fsm_n #(
        .N             (N),
        .STABLE_CYCLES (S)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .db      (db),
        .db_rise (db_rise),
        .db_fall (db_fall)
    );

    always #50 clk = ~clk;

    // Behavioural model
    initial begin
        for (int i = 0; i < N; i++) m_run[i] = 0;
        forever begin
            logic [N-1:0] s;
            @(posedge clk or posedge reset);
            if (reset) begin
                m_db   = '0;
                m_rise = '0;
                m_fall = '0;
                for (int i = 0; i < N; i++) m_run[i] = 0;
`ifdef DB_FSM_N_SYNC_EN
                m_q1 = '0;
                m_q2 = '0;
`endif
            end else begin
`ifdef DB_FSM_N_SYNC_EN
                s    = m_q2;
                m_q2 = m_q1;
                m_q1 = sw;
`else
                s = sw;
`endif
                for (int i = 0; i < N; i++) begin
                    m_rise[i] = 1'b0;
                    m_fall[i] = 1'b0;
                    if (s[i] != m_db[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == S + 1) begin
                            m_db[i] = s[i];
                            if (s[i]) m_rise[i] = 1'b1;
                            else      m_fall[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus tick counting
    initial begin
        for (int i = 0; i < N; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            check("db", int'(db), int'(m_db));
            check("db_rise", int'(db_rise), int'(m_rise));
            check("db_fall", int'(db_fall), int'(m_fall));
            n_checks++;
            if ((db_rise & db_fall) != '0) begin
                n_err++;
                $display("FAIL rise_fall_overlap: rise=%b fall=%b", db_rise, db_fall);
            end
            for (int i = 0; i < N; i++) begin
                rise_cnt[i] += int'(db_rise[i]);
                fall_cnt[i] += int'(db_fall[i]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts edges from the current negedge until db[ch]==val; returns on a negedge
    task automatic wait_db(input int ch, input logic val, input int exp_edges, input string name);
        int edges;
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (db[ch] == val) begin
                edges = k;
                break;
            end
        end
        check(name, edges, exp_edges);
        @(negedge clk);
    endtask

    initial begin
        #(100 * 5000);
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, r1, f0, f1;

        // Reset with inputs high, then qualify both channels
        @(negedge clk);
        check("reset_db", int'(db), 0);
        check("reset_pulses", int'({db_rise, db_fall}), 0);
        reset = 1'b0;
        wait_db(0, 1'b1, LAT, "reset_rel_latency");
        check("reset_rel_db_both", int'(db), 3);
        step(2);
        check("reset_rel_rise0", rise_cnt[0], 1);
        check("reset_rel_rise1", rise_cnt[1], 1);

        // Short glitch on ch1 must be filtered
        f1 = fall_cnt[1];
        sw = 2'b01;
        step(7);
        sw = 2'b11;
        step(LAT + 2);
        check("glitch_db", int'(db), 3);
        check("glitch_no_fall", fall_cnt[1] - f1, 0);

        // Both channels fall together
        f0 = fall_cnt[0];
        f1 = fall_cnt[1];
        sw = 2'b00;
        wait_db(0, 1'b0, LAT, "simul_latency");
        check("simul_db", int'(db), 0);
        check("simul_fall", int'(db_fall), 3);
        step(2);
        check("simul_fall_cnt0", fall_cnt[0] - f0, 1);
        check("simul_fall_cnt1", fall_cnt[1] - f1, 1);

        // Clean press on ch0
        r0 = rise_cnt[0];
        r1 = rise_cnt[1];
        sw = 2'b01;
        wait_db(0, 1'b1, LAT, "press_latency");
        check("press_db1", int'(db[1]), 0);
        step(12);
        check("press_rise0", rise_cnt[0] - r0, 1);
        check("press_rise1", rise_cnt[1] - r1, 0);

        // Bounce on ch0: qualification restarts from the last edge
        sw = 2'b00;
        step(12);
        check("bounce_pre_db", int'(db), 0);
        r0 = rise_cnt[0];
        sw = 2'b01;
        step(5);
        sw = 2'b00;
        step(1);
        check("bounce_mid_db", int'(db), 0);
        sw = 2'b01;
        wait_db(0, 1'b1, LAT, "bounce_latency");
        step(2);
        check("bounce_rise0", rise_cnt[0] - r0, 1);

        // Reset in the middle of WAIT1
        sw = 2'b00;
        step(12);
        r0 = rise_cnt[0];
        sw = 2'b01;
        step(4);
        reset = 1'b1;
        #1;
        check("midreset_db", int'(db), 0);
        check("midreset_pulses", int'({db_rise, db_fall}), 0);
        step(1);
        reset = 1'b0;
        wait_db(0, 1'b1, LAT, "midreset_latency");
        step(2);
        check("midreset_rise0", rise_cnt[0] - r0, 1);

        step(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
